// File: rtl/ysyx_24080006_axi_sram.sv
// AXI4-Lite responder SRAM model with one outstanding transaction and fixed response latency.
// Optional: define YSYX_24080006_AXI_RAND_DELAY_EN to add 0..3 LFSR-driven extra cycles per transaction.
module ysyx_24080006_axi_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LAT      = 1,
  parameter int          WR_LAT      = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  // Handshake rule on every channel: a transfer happens on a rising clock edge
  // where valid and ready are both 1; valid, once raised, holds with its payload
  // until that edge.

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_WAIT, WR_RESP
  } state_t;

  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [4:0]  RD_BASE = 5'(RD_LAT - 1);
  localparam logic [4:0]  WR_BASE = 5'(WR_LAT - 1);

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [31:0] ar_q, aw_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        have_aw, have_w;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] cur_araddr, cur_awaddr, cur_wdata;
  logic [3:0]  cur_wstrb;
  logic [31:0] rd_off, wr_off;
  logic        rd_ok, wr_ok;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic        ar_hs, aw_hs, w_hs;
  logic        rd_start, wr_start, rd_fire, wr_fire;
  logic [4:0]  rd_load, wr_load;
  logic [1:0]  extra;

`ifdef YSYX_24080006_AXI_RAND_DELAY_EN
  logic [7:0] lfsr;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= 8'hA5;
    else if (rd_start || wr_start)
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign extra = lfsr[1:0];
`else
  assign extra = 2'd0;
`endif

  // A channel already captured supplies its latched copy; the missing one is taken live.
  always_comb begin
    cur_araddr = (state == IDLE) ? araddr : ar_q;
    cur_awaddr = have_aw ? aw_q : awaddr;
    cur_wdata  = have_w ? wdata_q : wdata;
    cur_wstrb  = have_w ? wstrb_q : wstrb;
    rd_off     = cur_araddr - BASE_ADDR;
    wr_off     = cur_awaddr - BASE_ADDR;
    rd_ok      = {1'b0, rd_off} < SPAN;
    wr_ok      = {1'b0, wr_off} < SPAN;
    rd_idx     = rd_off[IDX_W+1:2];
    wr_idx     = wr_off[IDX_W+1:2];
    ar_hs      = arvalid & arready;
    aw_hs      = awvalid & awready;
    w_hs       = wvalid & wready;
    rd_load    = RD_BASE + {3'b000, extra};
    wr_load    = WR_BASE + {3'b000, extra};
    rd_start   = (state == IDLE) & ar_hs;
    wr_start   = ((state == IDLE) & aw_hs & w_hs) |
                 ((state == WR_COLLECT) & (aw_hs | w_hs));
    rd_fire    = (rd_start & (rd_load == 5'd0)) | ((state == RD_WAIT) & (cnt == 5'd1));
    wr_fire    = (wr_start & (wr_load == 5'd0)) | ((state == WR_WAIT) & (cnt == 5'd1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (aw_hs && w_hs)       state_next = (wr_load == 5'd0) ? WR_RESP : WR_WAIT;
        else if (aw_hs || w_hs)  state_next = WR_COLLECT;
        else if (ar_hs)          state_next = (rd_load == 5'd0) ? RD_RESP : RD_WAIT;
      end
      WR_COLLECT: if (aw_hs || w_hs) state_next = (wr_load == 5'd0) ? WR_RESP : WR_WAIT;
      RD_WAIT:    if (cnt == 5'd1)   state_next = RD_RESP;
      WR_WAIT:    if (cnt == 5'd1)   state_next = WR_RESP;
      RD_RESP:    if (rready)        state_next = IDLE;
      WR_RESP:    if (bready)        state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    case (state)
      IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        arready = ~awvalid & ~wvalid;
      end
      WR_COLLECT: begin
        awready = ~have_aw;
        wready  = ~have_w;
      end
      default: ;
    endcase
    arready = arready & ~reset;
    awready = awready & ~reset;
    wready  = wready & ~reset;
    rvalid  = (state == RD_RESP);
    bvalid  = (state == WR_RESP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= 5'd0;
      ar_q    <= 32'd0;
      aw_q    <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      have_aw <= 1'b0;
      have_w  <= 1'b0;
      rdata   <= 32'd0;
      rresp   <= 2'b00;
      bresp   <= 2'b00;
    end else begin
      if (rd_start) ar_q <= araddr;
      if (aw_hs) begin
        aw_q    <= awaddr;
        have_aw <= 1'b1;
      end
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
        have_w  <= 1'b1;
      end
      if (wr_start)      cnt <= wr_load;
      else if (rd_start) cnt <= rd_load;
      else if ((state == RD_WAIT || state == WR_WAIT) && cnt != 5'd0) cnt <= cnt - 5'd1;
      if (rd_fire) begin
        rdata <= rd_ok ? mem[rd_idx] : 32'd0;
        rresp <= rd_ok ? 2'b00 : 2'b11;
      end
      if (wr_fire) bresp <= wr_ok ? 2'b00 : 2'b11;
      if (state == WR_RESP && bready) begin
        have_aw <= 1'b0;
        have_w  <= 1'b0;
      end
    end
  end

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_fire && wr_ok) begin
      for (int i = 0; i < 4; i++)
        if (cur_wstrb[i]) mem[wr_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
    end
  end

endmodule
